keypad_hex_entry: RTL and testbench
===================================

// Module: keypad_hex_entry
// PURPOSE
//   Front-end operand entry stage: scans one 4x4 hex keypad (row/col one-hot), synchronises and
//   debounces presses, decodes one hex digit per press and left-shifts it into a 32-bit operand
//   register. Two instances (in1_*, in2_*) feed the FP16/FP32 multiplier core and its digit display.
// PARAMETERS
//   DEBOUNCE_CYCLES  3   consecutive stable synchronised cycles required to accept press or release (>=1)
//   CNT_W            8   width of debounce counter; must hold DEBOUNCE_CYCLES
// PORTS
//   clk        in   1   system clock
//   rst_n      in   1   asynchronous active-low reset
//   data_type  in   1   0 = FP16 (4 digits), 1 = FP32 (8 digits)
//   ce         in   1   clear-entry; synchronous, clears operand/count
//   key_row    in   4   keypad row, one-hot when pressed, 0 idle
//   key_col    in   4   keypad column, one-hot when pressed, 0 idle
//   operand    out  32  entered value, right-aligned, upper bits 0
//   digit_cnt  out  4   digits accepted since last clear (0..8)
//   full       out  1   digit_cnt == 4 (FP16) or 8 (FP32)
//   key_pulse  out  1   one-cycle strobe per accepted key (also when full)
//   key_hex    out  4   decoded digit, valid with key_pulse, held afterwards
//   multi_key  out  1   one-cycle strobe: non-one-hot, non-zero row/col seen (ghost press)
// BEHAVIOUR
//   Reset: all outputs 0, FSM IDLE, counters 0, sync flops 0.
//   Sync: key_row/key_col pass 2-flop synchroniser; code = {row_s,col_s}.
//   Decode (col 1000/0100/0010/0001): row1000 -> 1 2 3 4; row0100 -> 5 6 7 8;
//     row0010 -> 9 0 A B; row0001 -> C D E F. Valid iff row_s and col_s each exactly one-hot.
//   FSM:
//     IDLE:    valid code -> PRESS (cnt=1, latch code). Invalid non-zero -> multi_key pulse, stay.
//     PRESS:   same code -> cnt++; cnt reaches DEBOUNCE_CYCLES -> ACCEPT. Code differs/zero -> IDLE.
//     ACCEPT:  single cycle: key_pulse=1, key_hex=decoded; if !full: operand={operand[27:0],hex},
//              digit_cnt++; if full: operand unchanged -> HELD.
//     HELD:    wait code==0 for DEBOUNCE_CYCLES consecutive cycles -> IDLE; any non-zero restarts count.
//   Latency: key_pulse registered 2 (sync) + DEBOUNCE_CYCLES + 1 cycles after key lines settle
//     (=6 at defaults; minimum press width accepted = DEBOUNCE_CYCLES+1 cycles after sync).
//   Exactly one digit per press regardless of hold time; no auto-repeat.
//   Width: FP16 accepts max 4 digits -> operand[31:16]=0; FP32 max 8 digits.
//   full combinational from digit_cnt and data_type.
//   ce: operand=0, digit_cnt=0 next cycle; FSM keeps state (held key not re-accepted).
//     ce coincident with ACCEPT: ce wins, digit discarded, key_pulse still asserts.
//   data_type toggles (registered edge detect): same effect as ce.
//   Reset mid-press: everything clears asynchronously; key still held at release of reset is
//     re-debounced from IDLE and accepted once.
//   multi_key does not alter operand/count; in PRESS an invalid code aborts to IDLE.
// TESTING
//   1 Reset, FP16, press 3,E,4,C (6-cycle press, 10-cycle release) -> operand=0x00003E4C,
//     digit_cnt=4, full=1, four key_pulse strobes with key_hex 3,E,4,C.
//   2 FP16 full, press 7 -> key_pulse, key_hex=7, operand stays 0x00003E4C, digit_cnt=4.
//   3 ce, data_type=1, enter 3,F,C,9,8,0,0,0 -> operand=0x3FC98000, digit_cnt=8, full=1.
//   4 Hold key 5 for 50 cycles -> exactly one key_pulse; 2-cycle glitch press -> no pulse.
//   5 row=1100,col=0100 -> multi_key pulse, no key_pulse, operand unchanged.
//   6 Assert rst_n=0 during PRESS of key A -> all outputs 0; after release, held A accepted once,
//     operand=0x0000000A; toggle data_type -> operand=0, digit_cnt=0.

Source files
------------

// File: rtl/keypad_hex_entry.sv
// Hex keypad operand entry: synchronises and debounces a 4x4 keypad, then shifts
// one decoded digit per press into a right-aligned 32-bit operand (4 or 8 digits).
module keypad_hex_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 3,
  parameter int unsigned CNT_W           = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_type,
  input  logic        ce,
  input  logic [3:0]  key_row,
  input  logic [3:0]  key_col,
  output logic [31:0] operand,
  output logic [3:0]  digit_cnt,
  output logic        full,
  output logic        key_pulse,
  output logic [3:0]  key_hex,
  output logic        multi_key
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] PRESS  = 2'd1;
  localparam logic [1:0] ACCEPT = 2'd2;
  localparam logic [1:0] HELD   = 2'd3;

  localparam logic [CNT_W-1:0] DB_LIM = CNT_W'(DEBOUNCE_CYCLES);

  logic [1:0]       state;
  logic [3:0]       row_m, row_s, col_m, col_s;
  logic [7:0]       code, latched_code;
  logic             code_valid;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             dt_q, clear, multi_seen;
  logic [3:0]       latched_hex;

  function automatic logic [3:0] hex_of(input logic [7:0] c);
    logic [3:0] h;
    h = 4'h0;
    case (c)
      8'b1000_1000: h = 4'h1;
      8'b1000_0100: h = 4'h2;
      8'b1000_0010: h = 4'h3;
      8'b1000_0001: h = 4'h4;
      8'b0100_1000: h = 4'h5;
      8'b0100_0100: h = 4'h6;
      8'b0100_0010: h = 4'h7;
      8'b0100_0001: h = 4'h8;
      8'b0010_1000: h = 4'h9;
      8'b0010_0100: h = 4'h0;
      8'b0010_0010: h = 4'hA;
      8'b0010_0001: h = 4'hB;
      8'b0001_1000: h = 4'hC;
      8'b0001_0100: h = 4'hD;
      8'b0001_0010: h = 4'hE;
      8'b0001_0001: h = 4'hF;
      default:      h = 4'h0;
    endcase
    return h;
  endfunction

  always_comb begin
    code        = {row_s, col_s};
    code_valid  = $onehot(row_s) && $onehot(col_s);
    cnt_nxt     = cnt + 1'b1;
    clear       = ce | (data_type != dt_q);
    full        = data_type ? (digit_cnt == 4'd8) : (digit_cnt == 4'd4);
    latched_hex = hex_of(latched_code);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_m        <= '0;
      row_s        <= '0;
      col_m        <= '0;
      col_s        <= '0;
      dt_q         <= 1'b0;
      state        <= IDLE;
      cnt          <= '0;
      latched_code <= '0;
      multi_seen   <= 1'b0;
      key_pulse    <= 1'b0;
      key_hex      <= '0;
      multi_key    <= 1'b0;
      operand      <= '0;
      digit_cnt    <= '0;
    end else begin
      row_m     <= key_row;
      row_s     <= row_m;
      col_m     <= key_col;
      col_s     <= col_m;
      dt_q      <= data_type;
      key_pulse <= 1'b0;
      multi_key <= 1'b0;

      case (state)
        IDLE: begin
          if (code_valid) begin
            latched_code <= code;
            cnt          <= {{(CNT_W-1){1'b0}}, 1'b1};
            multi_seen   <= 1'b0;
            state        <= (DB_LIM <= {{(CNT_W-1){1'b0}}, 1'b1}) ? ACCEPT : PRESS;
          end else if (code != '0) begin
            // Strobe once per ghost press, re-armed when the lines go idle or valid
            if (!multi_seen) multi_key <= 1'b1;
            multi_seen <= 1'b1;
          end else begin
            multi_seen <= 1'b0;
          end
        end
        PRESS: begin
          if (code == latched_code) begin
            cnt <= cnt_nxt;
            if (cnt_nxt >= DB_LIM) state <= ACCEPT;
          end else begin
            state <= IDLE;
          end
        end
        ACCEPT: begin
          key_pulse <= 1'b1;
          key_hex   <= latched_hex;
          cnt       <= '0;
          state     <= HELD;
        end
        HELD: begin
          if (code == '0) begin
            if (cnt_nxt >= DB_LIM) begin
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt <= cnt_nxt;
            end
          end else begin
            cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase

      // Clear takes priority over a coincident accept; the strobe still fires
      if (clear) begin
        operand   <= '0;
        digit_cnt <= '0;
      end else if (state == ACCEPT && !full) begin
        operand   <= {operand[27:0], latched_hex};
        digit_cnt <= digit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_keypad_hex_entry.sv
// Directed self-checking bench for keypad_hex_entry at default parameters.
module tb_keypad_hex_entry;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        data_type = 1'b0;
  logic        ce = 1'b0;
  logic [3:0]  key_row = '0;
  logic [3:0]  key_col = '0;
  logic [31:0] operand;
  logic [3:0]  digit_cnt;
  logic        full;
  logic        key_pulse;
  logic [3:0]  key_hex;
  logic        multi_key;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned pulse_cnt = 0;
  int unsigned multi_cnt = 0;
  int unsigned last_lat = 0;
  logic [3:0]  hex_q[$];

  keypad_hex_entry #(.DEBOUNCE_CYCLES(3), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .data_type(data_type), .ce(ce),
    .key_row(key_row), .key_col(key_col), .operand(operand),
    .digit_cnt(digit_cnt), .full(full), .key_pulse(key_pulse),
    .key_hex(key_hex), .multi_key(multi_key)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (key_pulse) begin
      pulse_cnt++;
      hex_q.push_back(key_hex);
    end
    if (multi_key) multi_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold (row,col) for `hold` cycles then release for `rel` cycles; records
  // cycles from drive to first visible key_pulse in last_lat (0 if none).
  task automatic press(input logic [3:0] r, input logic [3:0] c, input int hold, input int rel);
    last_lat = 0;
    key_row = r;
    key_col = c;
    for (int i = 1; i <= hold; i++) begin
      @(posedge clk);
      #1;
      if (key_pulse && last_lat == 0) last_lat = i;
    end
    key_row = '0;
    key_col = '0;
    idle_cycles(rel);
  endtask

  task automatic press_hex(input logic [3:0] h);
    logic [3:0] r, c;
    case (h)
      4'h1: begin r = 4'b1000; c = 4'b1000; end
      4'h2: begin r = 4'b1000; c = 4'b0100; end
      4'h3: begin r = 4'b1000; c = 4'b0010; end
      4'h4: begin r = 4'b1000; c = 4'b0001; end
      4'h5: begin r = 4'b0100; c = 4'b1000; end
      4'h6: begin r = 4'b0100; c = 4'b0100; end
      4'h7: begin r = 4'b0100; c = 4'b0010; end
      4'h8: begin r = 4'b0100; c = 4'b0001; end
      4'h9: begin r = 4'b0010; c = 4'b1000; end
      4'h0: begin r = 4'b0010; c = 4'b0100; end
      4'hA: begin r = 4'b0010; c = 4'b0010; end
      4'hB: begin r = 4'b0010; c = 4'b0001; end
      4'hC: begin r = 4'b0001; c = 4'b1000; end
      4'hD: begin r = 4'b0001; c = 4'b0100; end
      4'hE: begin r = 4'b0001; c = 4'b0010; end
      default: begin r = 4'b0001; c = 4'b0001; end
    endcase
    press(r, c, 6, 10);
  endtask

  task automatic pulse_ce;
    ce = 1'b1;
    idle_cycles(1);
    ce = 1'b0;
    idle_cycles(1);
  endtask

  logic [3:0]  seq1[4] = '{4'h3, 4'hE, 4'h4, 4'hC};
  logic [3:0]  seq3[8] = '{4'h3, 4'hF, 4'hC, 4'h9, 4'h8, 4'h0, 4'h0, 4'h0};
  int unsigned p0;
  logic [3:0]  h;

  initial begin
    // 1: reset state, FP16 entry of 3,E,4,C
    idle_cycles(2);
    check("rst_operand", operand, 32'h0);
    check("rst_digit_cnt", {28'h0, digit_cnt}, 32'd0);
    check("rst_full", {31'h0, full}, 32'd0);
    check("rst_key_pulse", {31'h0, key_pulse}, 32'd0);
    check("rst_key_hex", {28'h0, key_hex}, 32'd0);
    check("rst_multi_key", {31'h0, multi_key}, 32'd0);
    rst_n = 1'b1;
    idle_cycles(3);
    press_hex(4'h3);
    check("latency_first_key", last_lat, 32'd6);
    for (int i = 1; i < 4; i++) press_hex(seq1[i]);
    check("fp16_operand", operand, 32'h0000_3E4C);
    check("fp16_digit_cnt", {28'h0, digit_cnt}, 32'd4);
    check("fp16_full", {31'h0, full}, 32'd1);
    check("fp16_pulses", pulse_cnt, 32'd4);
    for (int i = 0; i < 4; i++) begin
      h = (hex_q.size() > 0) ? hex_q.pop_front() : 4'hx;
      check($sformatf("fp16_hex%0d", i), {28'h0, h}, {28'h0, seq1[i]});
    end

    // 2: key when full still strobes but is not stored
    press_hex(4'h7);
    check("full_pulses", pulse_cnt, 32'd5);
    h = (hex_q.size() > 0) ? hex_q.pop_front() : 4'hx;
    check("full_hex", {28'h0, h}, 32'h7);
    check("full_operand", operand, 32'h0000_3E4C);
    check("full_digit_cnt", {28'h0, digit_cnt}, 32'd4);

    // 3: clear and FP32 entry
    data_type = 1'b1;
    pulse_ce;
    check("ce_operand", operand, 32'h0);
    check("ce_digit_cnt", {28'h0, digit_cnt}, 32'd0);
    check("fp32_not_full", {31'h0, full}, 32'd0);
    for (int i = 0; i < 8; i++) press_hex(seq3[i]);
    check("fp32_operand", operand, 32'h3FC9_8000);
    check("fp32_digit_cnt", {28'h0, digit_cnt}, 32'd8);
    check("fp32_full", {31'h0, full}, 32'd1);
    hex_q.delete();

    // 4: long hold yields one digit; 2-cycle glitch yields none
    pulse_ce;
    p0 = pulse_cnt;
    press(4'b0100, 4'b1000, 50, 10);
    check("hold_pulses", pulse_cnt - p0, 32'd1);
    check("hold_operand", operand, 32'h0000_0005);
    press(4'b1000, 4'b1000, 2, 10);
    check("glitch_pulses", pulse_cnt - p0, 32'd1);
    check("glitch_operand", operand, 32'h0000_0005);

    // 5: ghost press
    p0 = pulse_cnt;
    press(4'b1100, 4'b0100, 6, 10);
    check("ghost_multi", multi_cnt, 32'd1);
    check("ghost_pulses", pulse_cnt - p0, 32'd0);
    check("ghost_operand", operand, 32'h0000_0005);
    check("ghost_digit_cnt", {28'h0, digit_cnt}, 32'd1);

    // 6: reset during PRESS of A, key still held afterwards
    p0 = pulse_cnt;
    key_row = 4'b0010;
    key_col = 4'b0010;
    idle_cycles(4);
    rst_n = 1'b0;
    #1;
    check("midrst_operand", operand, 32'h0);
    check("midrst_digit_cnt", {28'h0, digit_cnt}, 32'd0);
    check("midrst_key_pulse", {31'h0, key_pulse}, 32'd0);
    idle_cycles(2);
    rst_n = 1'b1;
    idle_cycles(15);
    key_row = '0;
    key_col = '0;
    idle_cycles(10);
    check("midrst_pulses", pulse_cnt - p0, 32'd1);
    check("midrst_key_hex", {28'h0, key_hex}, 32'hA);
    check("midrst_operand_a", operand, 32'h0000_000A);
    data_type = 1'b0;
    idle_cycles(2);
    check("dt_toggle_operand", operand, 32'h0);
    check("dt_toggle_digit_cnt", {28'h0, digit_cnt}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout: simulation did not complete, limit 200000 ns");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
